// File: rtl/reflex_game_ctrl.sv
// Reflex trainer game sequencer: places targets from an LFSR, arms the hit
// detector, measures reaction time in ms and keeps the score for one round.
module reflex_game_ctrl #(
  parameter int unsigned BALL_SIZE   = 40,
  parameter int unsigned X_MAX       = 640,
  parameter int unsigned Y_MAX       = 480,
  parameter int unsigned TIMEOUT_MS  = 1500,
  parameter int unsigned COOLDOWN_MS = 300,
  parameter int unsigned GAME_BALLS  = 20,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_ms,
  input  logic        start_btn,
  input  logic        hit,
  output logic [9:0]  BALL_X,
  output logic [9:0]  BALL_Y,
  output logic        ball_visible,
  output logic        armed,
  output logic [7:0]  hits,
  output logic [7:0]  misses,
  output logic [11:0] last_rt_ms,
  output logic        game_over,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COOL  = 3'd1,
    S_SPAWN = 3'd2,
    S_ARMED = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [9:0]  XR      = 10'(X_MAX - BALL_SIZE);
  localparam logic [9:0]  YR      = 10'(Y_MAX - BALL_SIZE);
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_MS - 1);
  localparam logic [11:0] COOL_N  = 12'(COOLDOWN_MS);
  localparam logic [7:0]  N_BALLS = 8'(GAME_BALLS);

  state_t      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic        hit_q, hit_rise_q, start_q, start_rise_q;
  logic [11:0] cool_cnt_q, rt_cnt_q, last_rt_q;
  logic [7:0]  balls_q, hits_q, misses_q;
  logic [9:0]  ball_x_q, ball_y_q;
  logic        visible_q, armed_q, game_over_q;
  logic [9:0]  x_raw, y_raw, pos_x, pos_y;
  logic        timeout, ball_done;

  always_comb begin
    lfsr_d = (lfsr_q == 16'd0) ? LFSR_SEED
           : {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Single conditional subtract folds the raw value into the legal range.
    x_raw  = lfsr_q[9:0];
    y_raw  = {1'b0, lfsr_q[15:7]};
    pos_x  = (x_raw > XR) ? x_raw - (XR + 10'd1) : x_raw;
    pos_y  = (y_raw > YR) ? y_raw - (YR + 10'd1) : y_raw;
    timeout   = tick_ms && (rt_cnt_q == TO_LAST);
    ball_done = hit_rise_q || timeout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q       <= LFSR_SEED;
      hit_q        <= 1'b0;
      hit_rise_q   <= 1'b0;
      start_q      <= 1'b0;
      start_rise_q <= 1'b0;
    end else begin
      lfsr_q       <= lfsr_d;
      hit_q        <= hit;
      hit_rise_q   <= hit & ~hit_q;
      start_q      <= start_btn;
      start_rise_q <= start_btn & ~start_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cool_cnt_q  <= '0;
      rt_cnt_q    <= '0;
      last_rt_q   <= '0;
      balls_q     <= '0;
      hits_q      <= '0;
      misses_q    <= '0;
      ball_x_q    <= '0;
      ball_y_q    <= '0;
      visible_q   <= 1'b0;
      armed_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_rise_q) begin
            hits_q      <= '0;
            misses_q    <= '0;
            balls_q     <= '0;
            last_rt_q   <= '0;
            cool_cnt_q  <= '0;
            game_over_q <= 1'b0;
            state_q     <= S_COOL;
          end
        end
        S_COOL: begin
          // A detector still reporting a hit holds off the next target.
          if (cool_cnt_q == COOL_N && !hit) state_q <= S_SPAWN;
          else if (tick_ms && cool_cnt_q != COOL_N) cool_cnt_q <= cool_cnt_q + 12'd1;
        end
        S_SPAWN: begin
          ball_x_q  <= pos_x;
          ball_y_q  <= pos_y;
          rt_cnt_q  <= '0;
          visible_q <= 1'b1;
          armed_q   <= 1'b1;
          state_q   <= S_ARMED;
        end
        S_ARMED: begin
          if (ball_done) begin
            if (hit_rise_q) begin
              if (hits_q != 8'hFF) hits_q <= hits_q + 8'd1;
              last_rt_q <= rt_cnt_q;
            end else if (misses_q != 8'hFF) begin
              misses_q <= misses_q + 8'd1;
            end
            balls_q    <= balls_q + 8'd1;
            cool_cnt_q <= '0;
            visible_q  <= 1'b0;
            armed_q    <= 1'b0;
            if (balls_q + 8'd1 == N_BALLS) begin
              game_over_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              state_q <= S_COOL;
            end
          end else if (tick_ms && rt_cnt_q != 12'hFFF) begin
            rt_cnt_q <= rt_cnt_q + 12'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign BALL_X       = ball_x_q;
  assign BALL_Y       = ball_y_q;
  assign ball_visible = visible_q;
  assign armed        = armed_q;
  assign hits         = hits_q;
  assign misses       = misses_q;
  assign last_rt_ms   = last_rt_q;
  assign game_over    = game_over_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_reflex_game_ctrl.sv
// Bench for reflex_game_ctrl: directed rounds plus random play, all outputs
// compared every cycle against a behavioural game model.
module tb_reflex_game_ctrl;

  localparam int BS   = 40;
  localparam int XM   = 640;
  localparam int YM   = 480;
  localparam int TO   = 10;
  localparam int CD   = 3;
  localparam int NB   = 9;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int XR   = XM - BS;
  localparam int YR   = YM - BS;

  localparam int M_IDLE = 0, M_COOL = 1, M_SPAWN = 2, M_ARMED = 3, M_DONE = 4;

  logic        clk, rst_n, tick_ms, start_btn, hit;
  logic [9:0]  BALL_X, BALL_Y;
  logic        ball_visible, armed, game_over;
  logic [7:0]  hits, misses;
  logic [11:0] last_rt_ms;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int sc_hits, sc_misses, spawns;

  reflex_game_ctrl #(
    .BALL_SIZE(BS), .X_MAX(XM), .Y_MAX(YM), .TIMEOUT_MS(TO),
    .COOLDOWN_MS(CD), .GAME_BALLS(NB), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick_ms(tick_ms), .start_btn(start_btn), .hit(hit),
    .BALL_X(BALL_X), .BALL_Y(BALL_Y), .ball_visible(ball_visible), .armed(armed),
    .hits(hits), .misses(misses), .last_rt_ms(last_rt_ms), .game_over(game_over),
    .dbg_state_o(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // behavioural game model: phase, ms counters, input sample history
  int          m_phase, m_cool, m_rt, m_balls, m_hits, m_misses, m_last, m_x, m_y;
  logic [15:0] m_lfsr;
  bit          hit_hist[2], start_hist[2];
  bit          m_hit_rise, m_start_rise;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = M_IDLE; m_cool = 0; m_rt = 0; m_balls = 0; m_hits = 0;
      m_misses = 0; m_last = 0; m_x = 0; m_y = 0; m_lfsr = SEED;
      hit_hist[0] = 0; hit_hist[1] = 0; start_hist[0] = 0; start_hist[1] = 0;
    end else begin
      m_hit_rise   = hit_hist[0] && !hit_hist[1];
      m_start_rise = start_hist[0] && !start_hist[1];
      case (m_phase)
        M_IDLE, M_DONE:
          if (m_start_rise) begin
            m_hits = 0; m_misses = 0; m_balls = 0; m_last = 0; m_cool = 0;
            m_phase = M_COOL;
          end
        M_COOL:
          if (m_cool == CD && !hit) m_phase = M_SPAWN;
          else if (tick_ms && m_cool < CD) m_cool++;
        M_SPAWN: begin
          m_x = int'(m_lfsr[9:0]) % (XR + 1);
          m_y = int'(m_lfsr[15:7]) % (YR + 1);
          m_rt = 0;
          m_phase = M_ARMED;
        end
        default: begin
          if (m_hit_rise || (tick_ms && m_rt == TO - 1)) begin
            if (m_hit_rise) begin
              if (m_hits < 255) m_hits++;
              m_last = m_rt;
            end else if (m_misses < 255) m_misses++;
            m_balls++;
            m_cool = 0;
            m_phase = (m_balls == NB) ? M_DONE : M_COOL;
          end else if (tick_ms && m_rt < 4095) m_rt++;
        end
      endcase
      hit_hist[1] = hit_hist[0]; hit_hist[0] = hit;
      start_hist[1] = start_hist[0]; start_hist[0] = start_btn;
      m_lfsr = (m_lfsr == 16'd0) ? SEED
             : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  // scoreboard: every output every cycle, plus range check on each new target
  bit armed_prev = 0;
  always @(negedge clk) begin
    check("ball_x",       BALL_X,       m_x);
    check("ball_y",       BALL_Y,       m_y);
    check("ball_visible", ball_visible, m_phase == M_ARMED);
    check("armed",        armed,        m_phase == M_ARMED);
    check("hits",         hits,         m_hits);
    check("misses",       misses,       m_misses);
    check("last_rt_ms",   last_rt_ms,   m_last);
    check("game_over",    game_over,    m_phase == M_DONE);
    if (armed === 1'b1 && !armed_prev) begin
      spawns++;
      check("x_range", BALL_X <= XR, 1);
      check("y_range", BALL_Y <= YR, 1);
    end
    armed_prev = (armed === 1'b1);
  end

  // driver tasks (always entered at a falling edge)
  function automatic bit rnd_tick();
    return ($urandom_range(0, 2) == 0);
  endfunction

  task automatic drive(input bit t, input bit h, input bit s);
    tick_ms = t; hit = h; start_btn = s;
    @(negedge clk);
  endtask

  task automatic wait_armed();
    int n = 0;
    while (armed !== 1'b1 && n < 3000) begin
      drive(rnd_tick(), 1'b0, 1'b0);
      n++;
    end
    check("armed_wait", n < 3000, 1);
  endtask

  task automatic hit_ball(input int n);
    for (int k = 0; k < n; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0);
    check("hit_latency", hits, sc_hits);
    drive(1'b0, 1'b1, 1'b0);
    sc_hits++;
    check("hit_count", hits, sc_hits);
    check("hit_rt", last_rt_ms, n);
    check("hit_armed_off", armed, 0);
    check("hit_vis_off", ball_visible, 0);
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    check("arst_armed", armed, 0);
    check("arst_vis", ball_visible, 0);
    check("arst_hits", hits, 0);
    check("arst_misses", misses, 0);
    check("arst_rt", last_rt_ms, 0);
    check("arst_x", BALL_X, 0);
    check("arst_y", BALL_Y, 0);
    check("arst_over", game_over, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    int n, win_ticks, nwin, nt, k;
    bit was_armed, seen, hv;
    rst_n = 1'b0; tick_ms = 1'b0; start_btn = 1'b0; hit = 1'b0;
    spawns = 0;
    repeat (3) @(negedge clk);
    check("rst_hits", hits, 0);
    check("rst_over", game_over, 0);
    check("rst_armed", armed, 0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0);

    // round of pure timeouts: each armed window spans exactly TO ticks
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    n = 0; win_ticks = 0; nwin = 0;
    while (game_over !== 1'b1 && n < 5000) begin
      was_armed = (armed === 1'b1);
      tick_ms = rnd_tick();
      if (was_armed && tick_ms) win_ticks++;
      drive(tick_ms, 1'b0, 1'b0);
      if (was_armed && armed !== 1'b1) begin
        check("window_ticks", win_ticks, TO);
        win_ticks = 0;
        nwin++;
      end
      n++;
    end
    check("round1_end", n < 5000, 1);
    check("round1_windows", nwin, NB);
    check("round1_misses", misses, NB);
    check("round1_hits", hits, 0);

    // round with 7 hits and 2 misses
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    sc_hits = 0; sc_misses = 0;
    check("restart_over", game_over, 0);
    wait_armed();
    hit_ball(5);
    seen = 0;
    for (int i = 0; i < 4 * CD; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      if (armed === 1'b1) seen = 1;
    end
    check("hold_no_spawn", seen, 0);
    wait_armed();
    for (int i = 0; i < TO - 1; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b0);
    end
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    sc_hits++;
    check("tie_hits", hits, sc_hits);
    check("tie_misses", misses, 0);
    check("tie_rt", last_rt_ms, TO - 1);
    for (int b = 3; b <= 7; b++) begin
      wait_armed();
      hit_ball($urandom_range(0, TO - 2));
    end
    for (int b = 8; b <= NB; b++) begin
      wait_armed();
      n = 0;
      while (armed === 1'b1 && n < 500) begin
        drive(rnd_tick(), 1'b0, 1'b0);
        n++;
      end
      sc_misses++;
      check("miss_wait", n < 500, 1);
      check("miss_count", misses, sc_misses);
    end
    check("done_over", game_over, 1);
    check("done_hits", hits, 7);
    check("done_misses", misses, 2);
    repeat (5) drive(1'b1, 1'b0, 1'b0);
    check("done_hold_hits", hits, 7);

    // restart from DONE; first target appears after exactly CD ticks
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    check("new_hits", hits, 0);
    check("new_misses", misses, 0);
    check("new_over", game_over, 0);
    nt = 0; k = 0;
    while (armed !== 1'b1 && k < 200) begin
      drive(1'b1, 1'b0, 1'b0);
      nt++;
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      k++;
    end
    check("cool_ticks", nt, CD);

    // start pulse mid-target is ignored, then asynchronous reset
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    check("start_ignored_armed", armed, 1);
    check("start_ignored_hits", hits, 0);
    async_reset();
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      if (armed === 1'b1) seen = 1;
    end
    check("idle_after_reset", seen, 0);

    // random play
    hv = 0;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(0, 7) == 0) hv = ~hv;
      drive(rnd_tick(), hv, ($urandom_range(0, 150) == 0));
      if (i == 15000) async_reset();
    end
    check("spawn_count", spawns > 50, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
